alu_mc_pipe: RTL and testbench

- Parametrised, handshaked successor to the 32-bit ripple ALU.
- WIDTH-generic datapath with registered result and flags (cout, overflow, zero).
- Fixes signed set-less-than using the overflow correction, and adds unsigned SLT.
- Adds an iterative shift-add multiply (low WIDTH bits of the product).
- Sits in the EX stage of the pipeline. valid/ready on both sides lets the stall logic hold EX during a multiply.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_addsub_w.sv | 20 ++
 rtl/alu_mc_pipe.sv | 136 +++++++++++++
 tb/tb_alu_mc_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and FSM encodings for the handshaked multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_RSV  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_addsub_w.sv
// WIDTH-bit combinational adder/subtractor shared by ADD, SUB, SLT and SLTU.
module alu_addsub_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  // subtract as A + ~B + 1 so cout=1 means no borrow
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_mc_pipe.sv
// EX-stage ALU with valid/ready on both sides: single-cycle logic/arith ops and
// an iterative shift-add multiply that holds in_ready low while it runs.
module alu_mc_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
  } resp_t;

  state_t           state, state_nxt;
  resp_t            alu_resp, mul_resp, out_q;
  logic             accept, is_mul, mul_last;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout, as_ovf, as_sub;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);
  assign as_sub   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign mul_last = (state == ST_MUL) && (cnt == CNT_W'(WIDTH - 1));

  alu_addsub_w #(.WIDTH(WIDTH)) u_addsub (
    .a   (ina),
    .b   (inb),
    .sub (as_sub),
    .sum (as_sum),
    .cout(as_cout),
    .ovf (as_ovf)
  );

  always_comb begin
    alu_resp = '0;
    case (op)
      OP_AND:  alu_resp.result = ina & inb;
      OP_OR:   alu_resp.result = ina | inb;
      OP_ADD, OP_SUB: begin
        alu_resp.result   = as_sum;
        alu_resp.cout     = as_cout;
        alu_resp.overflow = as_ovf;
      end
      // sign of the difference corrected by overflow gives true signed order
      OP_SLT:  alu_resp.result = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      OP_SLTU: alu_resp.result = {{(WIDTH-1){1'b0}}, ~as_cout};
      default: alu_resp.result = '0;
    endcase
    if (op != OP_RSV)
      alu_resp.zero = (alu_resp.result == '0);
  end

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_resp = '{result: acc_nxt, cout: 1'b0, overflow: 1'b0, zero: (acc_nxt == '0)};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_last)         state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  end

  // output register; accept and mul_last are mutually exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (accept && !is_mul) begin
      out_q     <= alu_resp;
      out_valid <= 1'b1;
    end else if (mul_last) begin
      out_q     <= mul_resp;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= ina;
      mplier <= inb;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ST_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign result   = out_q.result;
  assign cout     = out_q.cout;
  assign overflow = out_q.overflow;
  assign zero     = out_q.zero;

endmodule

// File: tb/tb_alu_mc_pipe.sv
// Self-checking bench for alu_mc_pipe: directed tables for WIDTH=32 and 8,
// handshake corner sequences, and randomized traffic against an arithmetic model.
module tb_alu_mc_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, c32, v32, z32;
  logic [31:0] a32, b32, res32;
  logic [2:0]  op32;
  logic        iv8, ir8, ov8, or8, c8, v8, z8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;

  alu_mc_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .ina(a32), .inb(b32),
    .op(op32), .out_valid(ov32), .out_ready(or32), .result(res32), .cout(c32),
    .overflow(v32), .zero(z32)
  );

  alu_mc_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .ina(a8), .inb(b8),
    .op(op8), .out_valid(ov8), .out_ready(or8), .result(res8), .cout(c8),
    .overflow(v8), .zero(z8)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic straight from the op definitions, w-bit wrap.
  function automatic void model(input int w, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output logic [2:0] f);
    longint one, mask, ua, ub, sa, sb, smax, smin, t, s;
    logic c, v;
    one  = 1;
    mask = (one << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    smax = (one << (w - 1)) - 1;
    smin = -(one << (w - 1));
    c = 1'b0; v = 1'b0; t = 0;
    case (o)
      3'b000: t = ua & ub;
      3'b001: t = ua | ub;
      3'b010: begin t = (ua + ub) & mask; c = (ua + ub) > mask; s = sa + sb; v = (s > smax) || (s < smin); end
      3'b110: begin t = (ua - ub) & mask; c = (ua >= ub);       s = sa - sb; v = (s > smax) || (s < smin); end
      3'b111: t = (sa < sb) ? 1 : 0;
      3'b011: t = (ua < ub) ? 1 : 0;
      3'b100: t = (ua * ub) & mask;
      default: t = 0;
    endcase
    r = 32'(t);
    f = {c, v, (o != 3'b101) && (t == 0)};
  endfunction

  // Issue one op with out_ready high; report outputs, latency and whether in_ready rose early.
  task automatic do_op(input bit s8, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [2:0] f, output int lat, output bit ir_bad);
    int n;
    @(negedge clk);
    if (s8) begin iv8 = 1'b1; op8 = o; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin iv32 = 1'b1; op32 = o; a32 = a; b32 = b; end
    #1;
    n = 0;
    while (!(s8 ? ir8 : ir32) && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) chk("accept_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; iv32 = 1'b0;
    lat = 1; ir_bad = 1'b0;
    while (!(s8 ? ov8 : ov32) && lat < 200) begin
      if (s8 ? ir8 : ir32) ir_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    r = s8 ? {24'd0, res8} : res32;
    f = s8 ? {c8, v8, z8} : {c32, v32, z32};
  endtask

  typedef struct {
    bit          s8;
    logic [2:0]  op;
    logic [31:0] a, b, er;
    logic [2:0]  ef;   // {cout, overflow, zero}
    int          elat;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
  } exp_t;

  vec_t vecs[$];
  exp_t q[$];

  initial begin
    logic [31:0] r, er;
    logic [2:0]  f, ef;
    int          lat;
    bit          irb, bad;

    rst = 1'b1;
    iv32 = 0; or32 = 1; a32 = 0; b32 = 0; op32 = 0;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'd0, ov32}, 0);
    chk("rst_result", {32'd0, res32}, 0);
    chk("rst_flags", {61'd0, c32, v32, z32}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, ir32}, 1);

    vecs = '{
      '{0, 3'b010, 32'hFFFF_FFFF, 32'h1,        32'h0,        3'b101, 1},
      '{0, 3'b110, 32'h8000_0000, 32'h1,        32'h7FFF_FFFF, 3'b110, 1},
      '{0, 3'b111, 32'h8000_0000, 32'h1,        32'h1,        3'b000, 1},
      '{0, 3'b011, 32'h8000_0000, 32'h1,        32'h0,        3'b001, 1},
      '{0, 3'b100, 32'h0001_2345, 32'h100,      32'h0123_4500, 3'b000, 33},
      '{0, 3'b010, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 3'b010, 1},
      '{0, 3'b110, 32'h5,         32'h5,        32'h0,        3'b101, 1},
      '{0, 3'b110, 32'h3,         32'h5,        32'hFFFF_FFFE, 3'b000, 1},
      '{0, 3'b111, 32'h5,         32'h3,        32'h0,        3'b001, 1},
      '{0, 3'b101, 32'h1234,      32'h5678,     32'h0,        3'b000, 1},
      '{1, 3'b100, 32'h0F,        32'h11,       32'hFF,       3'b000, 9},
      '{1, 3'b000, 32'hF0,        32'h3C,       32'h30,       3'b000, 1},
      '{1, 3'b001, 32'hF0,        32'h0F,       32'hFF,       3'b000, 1},
      '{1, 3'b101, 32'hFF,        32'hFF,       32'h0,        3'b000, 1},
      '{1, 3'b010, 32'h80,        32'h80,       32'h0,        3'b111, 1},
      '{1, 3'b110, 32'h00,        32'h01,       32'hFF,       3'b000, 1},
      '{1, 3'b111, 32'h80,        32'h7F,       32'h1,        3'b000, 1},
      '{1, 3'b100, 32'hFF,        32'hFF,       32'h01,       3'b000, 9}
    };

    foreach (vecs[i]) begin
      do_op(vecs[i].s8, vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, irb);
      chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].er});
      chk($sformatf("vec%0d_flags", i), {61'd0, f}, {61'd0, vecs[i].ef});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].elat));
      if (vecs[i].op == 3'b100) begin
        chk($sformatf("vec%0d_busy_in_ready", i), {63'd0, irb}, 0);
        chk($sformatf("vec%0d_done_in_ready", i), {63'd0, vecs[i].s8 ? ir8 : ir32}, 1);
      end
    end

    // Backpressure: 1+2 then 3+4 while the consumer stalls for 3 cycles.
    @(negedge clk);
    or32 = 1'b0; iv32 = 1'b1; op32 = 3'b010; a32 = 1; b32 = 2;
    @(posedge clk);
    @(negedge clk);
    a32 = 3; b32 = 4;
    #1;
    chk("bp_first_valid", {63'd0, ov32}, 1);
    bad = 1'b0;
    repeat (3) begin
      if (ir32 !== 1'b0 || res32 !== 32'd3) bad = 1'b1;
      @(negedge clk);
    end
    chk("bp_hold_stable", {63'd0, bad}, 0);
    or32 = 1'b1;
    #1;
    chk("bp_ready_on_drain", {63'd0, ir32}, 1);
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    chk("bp_second_valid", {63'd0, ov32}, 1);
    chk("bp_second_result", {32'd0, res32}, 7);

    // Reset in the middle of a multiply: nothing may come out afterwards.
    @(negedge clk);
    iv32 = 1'b1; op32 = 3'b100; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF1;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", {63'd0, ov32}, 0);
    chk("mrst_result", {32'd0, res32}, 0);
    chk("mrst_in_ready", {63'd0, ir32}, 1);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) bad = 1'b1;
    end
    chk("mrst_no_stale", {63'd0, bad}, 0);

    // Randomized traffic with random backpressure, scoreboarded.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      or32 = ($urandom_range(0, 3) != 0);
      iv32 = $urandom_range(0, 1);
      op32 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a32 = 32'h8000_0000;
        1:       a32 = 32'($urandom_range(0, 7));
        default: a32 = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b32 = 32'hFFFF_FFFF;
        1:       b32 = 32'($urandom_range(0, 7));
        default: b32 = $urandom;
      endcase
      #1;
      if (ov32 && or32) begin
        if (q.size() == 0) chk("rnd_spurious_output", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rnd_result", {32'd0, res32}, {32'd0, e.r});
          chk("rnd_flags", {61'd0, c32, v32, z32}, {61'd0, e.f});
        end
      end
      if (iv32 && ir32) begin
        model(32, op32, a32, b32, er, ef);
        q.push_back('{er, ef});
      end
    end
    @(negedge clk);
    iv32 = 1'b0; or32 = 1'b1;
    for (int cyc = 0; cyc < 60 && q.size() != 0; cyc++) begin
      #1;
      if (ov32) begin
        exp_t e;
        e = q.pop_front();
        chk("drain_result", {32'd0, res32}, {32'd0, e.r});
        chk("drain_flags", {61'd0, c32, v32, z32}, {61'd0, e.f});
      end
      @(negedge clk);
    end
    chk("drain_queue_empty", 64'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
